ld_st_sequencer: RTL
====================

# ld_st_sequencer

Multi-cycle control sequencer for the load/store instruction class: `ld`, `ldi` and `st`. It sits directly upstream of the general-purpose register file and its select-and-encode logic. It generates the per-step control strobes, including `BAout`, which forces R0 to read as zero during base-address formation, plus the register-file read/write enables and the ALU, MAR/MDR and memory strobes. One instruction is sequenced per `start` pulse; all strobes are Moore outputs decoded from the state register.

## Interface
Parameters:
- `OPCODE_LD`, 5'b00000, opcode value for `ld Ra, C(Rb)`
- `OPCODE_LDI`, 5'b00001, opcode value for `ldi Ra, C(Rb)`
- `OPCODE_ST`, 5'b00010, opcode value for `st C(Rb), Ra`
- `MEM_WAIT`, 2, memory access cycles (1..15) spent in READ/WRITE

Ports:
- `clock` in 1: single clock, rising edge
- `clear` in 1: reset, asynchronous, active-high
- `start` in 1: one-cycle pulse; IR holds a new instruction
- `ir` in 32: instruction register contents (opcode [31:27], Ra [26:23], Rb [22:19], C [18:0]); stable while `busy`
- `Gra`, `Grb` out 1: select the Ra / Rb field for the select-and-encode logic
- `Rin`, `Rout` out 1: write / drive the selected register
- `BAout` out 1: base-address read; R0 reads as 0
- `Cout` out 1: drive sign-extended C onto the bus
- `Yin`, `Zin`, `Zlowout` out 1: Y load, Z load, Z-low drive
- `alu_add` out 1: ALU operation = ADD
- `MARin`, `MDRin`, `MDRout` out 1: MAR/MDR strobes
- `Read`, `Write` out 1: memory strobes
- `busy` out 1: high from the cycle after an accepted `start` through the DONE state
- `done` out 1: one-cycle pulse in the DONE state
- `illegal` out 1: one-cycle pulse when `start` arrives with a non-load/store opcode

## Operation
- States: IDLE, T3, T4, T5, T6, T7, DONE.
- The opcode is latched into an internal `op` register on an accepted `start`.
- IDLE: all strobes 0.
  - `start` with a matching opcode → T3.
  - `start` with any other opcode → stay in IDLE; `illegal`=1 for the next cycle.
- T3: `Grb`, `Rout`, `BAout`, `Yin`.
- T4: `Cout`, `alu_add`, `Zin`.
- T5:
  - ld/st: `Zlowout`, `MARin` → T6.
  - ldi: `Zlowout`, `Gra`, `Rin` → DONE.
- T6:
  - ld: `Read`, `MDRin`, held for `MEM_WAIT` cycles → T7.
  - st: `Gra`, `Rout`, `MDRin` for one cycle → T7.
- T7:
  - ld: `MDRout`, `Gra`, `Rin` for one cycle → DONE.
  - st: `Write`, held for `MEM_WAIT` cycles → DONE.
- DONE: `done`=1 → IDLE.
- Wait counter: 4-bit, loaded with `MEM_WAIT-1` on entry to a memory state; it decrements each cycle, and the state exits when the count is 0.
- `start` while `busy` is ignored: no state change and no `illegal`.
- `clear` asserted at any time returns the block to IDLE immediately (asynchronously) and zeroes the counter, `op` and every output, including mid-READ/WRITE. Memory-side abort handling is the memory controller's responsibility.
- Rb=0 case: `BAout` in T3 makes the effective address C alone. The sequencer does not inspect Rb.

## Timing
- Reset value of every output: 0; `busy`=0.
- Accepted `start` is sampled at edge 0; T3 is active in cycle 1.
- Total cycles from `start` to the `done` cycle:
  - ldi: 4 (T3, T4, T5, DONE)
  - ld: 5+`MEM_WAIT` (T3, T4, T5, T6×`MEM_WAIT`, T7, DONE)
  - st: 5+`MEM_WAIT` (T3, T4, T5, T6, T7×`MEM_WAIT`, DONE)
- Default `MEM_WAIT`=2 gives 7 cycles for ld and st.
- A new `start` is accepted in the cycle after DONE, when the block is back in IDLE. Back-to-back instructions therefore have no dead cycle beyond DONE.
- `illegal` is registered: it is high exactly one cycle, in the cycle after the offending `start`.
- Strobes are functions of state (and `op`) only; no combinational path from `start` or `ir` to any strobe.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state enumeration
  - the opcode constants (shared with the main control unit)
  - the instruction-field bit positions
- Sub-module `mem_wait_counter` (load, decrement, zero flag, async `clear`) is instantiated once; it is reusable by the other memory-touching sequencers.

## Test plan
- **Reset:** hold `clear` 3 cycles → all outputs 0, `busy`=0. Release, idle 5 cycles → outputs remain 0.
- **ldi:** `ir`=32'h08A0_0054 (ldi R1, 0x54(R4)) with a `start` pulse → strobe sequence T3 {`Grb`, `Rout`, `BAout`, `Yin`}, T4 {`Cout`, `alu_add`, `Zin`}, T5 {`Zlowout`, `Gra`, `Rin`} → `done` in cycle 4.
- **ld, `MEM_WAIT`=2:** `ir`=32'h0090_0054 with `start` → `Read` and `MDRin` high for exactly cycles 4–5, T7 {`MDRout`, `Gra`, `Rin`} in cycle 6, `done` in cycle 7.
- **st, `MEM_WAIT`=3:** `ir`=32'h1090_0063 with `start` → T6 {`Gra`, `Rout`, `MDRin`} in cycle 4, `Write` high in cycles 5–7, `done` in cycle 8.
- **Illegal and busy:** `start` with opcode 5'b00011 → `illegal` pulses in cycle 1, no state change. `start` pulsed during T4 of an ld → ignored; exactly one `done` is produced.
- **Clear mid-operation:** assert `clear` during the second READ cycle of an ld → `Read` and `MDRin` drop immediately. After release, a new ldi completes normally in 4 cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer states, opcodes
// and instruction-field bit positions.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_DONE
  } seq_state_t;

  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

  function automatic logic [4:0] ir_opcode(
    input logic [31:0] ir
  );
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing multi-cycle memory states; reusable
// by any sequencer that holds a strobe for a fixed latency.
module mem_wait_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ld_st_sequencer.sv
// Multi-cycle control sequencer for ld / ldi / st; all
// strobes are Moore outputs decoded from state and op.
module ld_st_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0] OPCODE_LD  = OPC_LD,
  parameter logic [4:0] OPCODE_LDI = OPC_LDI,
  parameter logic [4:0] OPCODE_ST  = OPC_ST,
  parameter int         MEM_WAIT   = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  output logic        Gra,
  output logic        Grb,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Cout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        alu_add,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

  seq_state_t state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  logic [4:0] opc;
  logic       legal;
  logic       is_ld, is_ldi, is_st;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       unused_fields;

  assign opc    = ir_opcode(ir);
  assign legal  = (opc == OPCODE_LD) || (opc == OPCODE_LDI)
               || (opc == OPCODE_ST);
  assign is_ld  = (op_q == OPCODE_LD);
  assign is_ldi = (op_q == OPCODE_LDI);
  assign is_st  = (op_q == OPCODE_ST);

  // Register fields are consumed by select-and-encode, not here.
  assign unused_fields = ^ir[RA_MSB:C_LSB];

  mem_wait_counter #(
    .W(4)
  ) u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (legal) begin
            state_d = S_T3;
            op_d    = opc;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (is_ldi) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_T6;
          cnt_load = is_ld;
        end
      end
      S_T6: begin
        if (is_ld) begin
          if (cnt_zero) state_d = S_T7;
          else          cnt_dec = 1'b1;
        end else begin
          state_d  = S_T7;
          cnt_load = 1'b1;
        end
      end
      S_T7: begin
        if (is_st && !cnt_zero) cnt_dec = 1'b1;
        else                    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    Gra     = 1'b0;
    Grb     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    alu_add = 1'b0;
    MARin   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    unique case (state_q)
      S_T3: begin
        Grb   = 1'b1;
        Rout  = 1'b1;
        BAout = 1'b1;
        Yin   = 1'b1;
      end
      S_T4: begin
        Cout    = 1'b1;
        alu_add = 1'b1;
        Zin     = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        Gra     = is_ldi;
        Rin     = is_ldi;
        MARin   = !is_ldi;
      end
      S_T6: begin
        MDRin = 1'b1;
        Read  = is_ld;
        Gra   = is_st;
        Rout  = is_st;
      end
      S_T7: begin
        Write  = is_st;
        MDRout = is_ld;
        Gra    = is_ld;
        Rin    = is_ld;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign illegal = illegal_q;

endmodule
